// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit handshaked ALU with registered result/flags, a persistent
// carry flag (cf) for multi-word chaining, shifts, and a WIDTH-cycle shift-add
// multiplier. Single-cycle ops: result valid the edge after accept. MUL: result
// valid WIDTH edges after accept. Accepts only in IDLE when the result register
// is empty or being drained this edge.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_valid/o_ready                request handshake (i_op, i_a, i_b, i_carry_ce)
//   o_valid/i_ready                result handshake (o_result, o_carry, o_zero,
//                                  o_neg, o_ovf)
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_ce,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_PASS = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               cf;

  logic               accept;
  logic               sink_ok;
  logic               mul_last;
  logic               mul_start;
  logic               load_alu;
  logic               load_mul;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mul_prod;

  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_cf_upd;

  assign accept   = i_valid && o_ready;
  // Result register can take a new value: empty now, or emptied at this edge.
  assign sink_ok  = !o_valid || i_ready;
  assign mul_last = (cnt == CW'(WIDTH - 1));
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  // On the final MUL step the product includes this cycle's partial sum;
  // in WAIT the accumulator already holds the complete product.
  assign mul_prod = (state == S_MUL) ? acc_step : acc;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next-state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mul_start) state_nxt = S_MUL;
      S_MUL:  if (mul_last)  state_nxt = sink_ok ? S_IDLE : S_WAIT;
      S_WAIT: if (sink_ok)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_ready   = (state == S_IDLE) && sink_ok;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    if (state == S_IDLE && i_valid && sink_ok) begin
      mul_start = (i_op == OP_MUL);
      load_alu  = (i_op != OP_MUL);
    end
    if ((state == S_MUL && mul_last && sink_ok) || (state == S_WAIT && sink_ok)) begin
      load_mul = 1'b1;
    end
  end

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    cin        = i_carry_ce & cf;
    sum        = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, cin};
    diff       = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, cin};
    alu_res    = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    alu_cf_upd = 1'b0;
    case (i_op)
      OP_ADD: begin
        alu_res    = sum[WIDTH-1:0];
        alu_carry  = sum[WIDTH];
        alu_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
        alu_cf_upd = 1'b1;
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        alu_res    = diff[WIDTH-1:0];
        alu_carry  = diff[WIDTH];
        alu_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
        alu_cf_upd = 1'b1;
      end
      OP_AND:  alu_res = i_a & i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_NOT:  alu_res = ~i_a;
      OP_PASS: alu_res = i_b;
      OP_SHL: begin
        alu_res    = {i_a[WIDTH-2:0], cin};
        alu_carry  = i_a[WIDTH-1];
        alu_cf_upd = 1'b1;
      end
      OP_SHR: begin
        alu_res    = {cin, i_a[WIDTH-1:1]};
        alu_carry  = i_a[0];
        alu_cf_upd = 1'b1;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // ---------------- multiplier datapath ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_start) begin
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, i_a};
      mplier <= i_b;
      acc    <= '0;
    end else if (state == S_MUL) begin
      cnt    <= cnt + CW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_step;
    end
  end

  // ---------------- result register and carry flag ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_carry  <= 1'b0;
      o_zero   <= 1'b0;
      o_neg    <= 1'b0;
      o_ovf    <= 1'b0;
      cf       <= 1'b0;
    end else if (load_alu) begin
      o_valid  <= 1'b1;
      o_result <= alu_res;
      o_carry  <= alu_carry;
      o_zero   <= (alu_res == '0);
      o_neg    <= alu_res[WIDTH-1];
      o_ovf    <= alu_ovf;
      if (alu_cf_upd) cf <= alu_carry;
    end else if (load_mul) begin
      o_valid  <= 1'b1;
      o_result <= mul_prod[WIDTH-1:0];
      o_carry  <= |mul_prod[2*WIDTH-1:WIDTH];
      o_zero   <= (mul_prod[WIDTH-1:0] == '0);
      o_neg    <= mul_prod[WIDTH-1];
      o_ovf    <= 1'b0;
      cf       <= |mul_prod[2*WIDTH-1:WIDTH];
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq (WIDTH=8) against an arithmetic
// reference model; results are checked in order through a scoreboard queue.
module tb_alu_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       i_carry_ce;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_result;
  logic       o_carry;
  logic       o_zero;
  logic       o_neg;
  logic       o_ovf;

  alu_seq #(.WIDTH(8)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_carry_ce (i_carry_ce),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_carry    (o_carry),
    .o_zero     (o_zero),
    .o_neg      (o_neg),
    .o_ovf      (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad = 0;
  int          n_push = 0;
  int          n_pop = 0;
  logic [11:0] exp_q[$];
  logic        mcf;
  bit          rand_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  task automatic push_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic ce);
    int ua, ub, sa, sb, cin, s, sv, r;
    logic c, v, upd;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    cin = ce ? int'(mcf) : 0;
    r = 0; c = 1'b0; v = 1'b0; upd = 1'b0;
    case (op)
      4'd0: begin
        s = ua + ub + cin; r = s % 256; c = (s > 255);
        sv = sa + sb + cin; v = (sv > 127) || (sv < -128); upd = 1'b1;
      end
      4'd1: begin
        s = ua - ub - cin; r = s & 255; c = (s < 0);
        sv = sa - sb - cin; v = (sv > 127) || (sv < -128); upd = 1'b1;
      end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (~ua) & 255;
      4'd6: r = ub;
      4'd7: begin r = (ua * 2 + cin) % 256; c = (ua >= 128); upd = 1'b1; end
      4'd8: begin r = ua / 2 + cin * 128; c = (ua % 2 == 1); upd = 1'b1; end
      4'd9: begin s = ua * ub; r = s % 256; c = (s > 255); upd = 1'b1; end
      default: r = 0;
    endcase
    if (upd) mcf = c;
    exp_q.push_back({r[7:0], c, (r == 0), (r >= 128), v});
    n_push++;
  endtask

  // Issue one request; returns at accept edge + 1.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ce);
    int tries;
    bit acc;
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_carry_ce = ce;
    tries = 0; acc = 1'b0;
    while (!acc && tries < 200) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      if (!acc) begin
        tries++;
        if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
      end
    end
    if (acc) push_model(op, a, b, ce);
    else chk("accept_timeout", 32'(o_ready), 32'd1);
    if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    // Scramble inputs after accept: the DUT must have sampled them already.
    i_valid = 1'b0; i_op = 4'($urandom); i_a = 8'($urandom); i_b = 8'($urandom);
    i_carry_ce = 1'($urandom);
  endtask

  // Count edges after a MUL accept until o_valid; also count o_ready=1 sightings.
  task automatic wait_valid(output int edges, output int rdy_seen);
    bit got;
    edges = 0; rdy_seen = 0; got = 1'b0;
    while (!got && edges < 50) begin
      @(negedge i_clk);
      if (o_valid) got = 1'b1;
      else begin
        if (o_ready) rdy_seen++;
        @(posedge i_clk);
        #1;
        edges++;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    i_ready = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && t < 100) begin
      @(posedge i_clk);
      #1;
      t++;
    end
  endtask

  // Scoreboard: every consumed result must match the oldest expected one.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(o_valid), 32'd0);
      end else begin
        n_pop++;
        chk("result", 32'({o_result, o_carry, o_zero, o_neg, o_ovf}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int edges, rdy_seen;
    logic [11:0] e1;
    logic [7:0] x, y;
    i_rst_n = 1'b0; i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    i_carry_ce = 1'b0; i_ready = 1'b1; mcf = 1'b0; rand_rdy = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_outs", 32'({o_result, o_carry, o_zero, o_neg, o_ovf}), 32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ready_after_rst", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;

    // Carry chaining and subtraction
    send(4'd0, 8'hFF, 8'h01, 1'b0);
    send(4'd0, 8'h00, 8'h00, 1'b1);
    send(4'd1, 8'h05, 8'h07, 1'b0);
    send(4'd1, 8'h80, 8'h01, 1'b0);
    drain();

    // MUL latency and o_ready low throughout
    send(4'd9, 8'h10, 8'h11, 1'b0);
    wait_valid(edges, rdy_seen);
    chk("mul1_latency", 32'(edges), 32'd8);
    chk("mul1_ready_low", 32'(rdy_seen), 32'd0);
    @(posedge i_clk); #1;
    send(4'd9, 8'h0F, 8'h0F, 1'b0);
    wait_valid(edges, rdy_seen);
    chk("mul2_latency", 32'(edges), 32'd8);
    chk("mul2_ready_low", 32'(rdy_seen), 32'd0);
    @(posedge i_clk); #1;
    drain();

    // Backpressure: first result held, second op offered but not taken
    i_ready = 1'b0;
    x = 8'($urandom); y = 8'($urandom);
    send(4'd2, x, y, 1'b0);
    e1 = exp_q[0];
    x = 8'($urandom); y = 8'($urandom);
    i_valid = 1'b1; i_op = 4'd3; i_a = x; i_b = y; i_carry_ce = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      chk("bp_hold", 32'({o_result, o_carry, o_zero, o_neg, o_ovf}), 32'(e1));
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    send(4'd3, x, y, 1'b0);
    send(4'd4, 8'($urandom), 8'($urandom), 1'b0);
    drain();

    // Illegal opcode preserves cf
    send(4'd7, 8'h80, 8'h00, 1'b0);
    send(4'hC, 8'($urandom), 8'($urandom), 1'b1);
    send(4'd8, 8'h00, 8'h00, 1'b1);
    drain();

    // Reset in the middle of a MUL
    send(4'd9, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    exp_q.delete();
    n_push = n_push - 1;
    mcf = 1'b0;
    @(negedge i_clk);
    chk("rstmul_valid", 32'(o_valid), 32'd0);
    chk("rstmul_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (12) @(posedge i_clk);
    #1;
    send(4'd0, 8'h00, 8'h00, 1'b1);
    drain();

    // Randomized traffic with random downstream stalls
    rand_rdy = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge i_clk); #1;
        i_ready = ($urandom_range(0, 3) != 0);
      end
      send(4'($urandom_range(0, 11)), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    rand_rdy = 1'b0;
    drain();
    @(negedge i_clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("push_pop", 32'(n_pop), 32'(n_push));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
